// File: rtl/key_conditioner.sv
// key_conditioner
//   Conditions raw active-low push buttons for the lock controller. Each key
//   is synchronised (2 flops), debounced by its own FSM and turned into a
//   clean level plus single-cycle press/release pulses. mask suppresses
//   press pulses only.
//
//   Optional feature: define KEY_COND_REPEAT_EN to enable auto-repeat press
//   pulses while a key stays held.
//
// Ports
//   clk           system clock
//   system_reset  asynchronous, active-high reset
//   key_n         raw buttons, active-low, asynchronous to clk
//   mask          high: suppress key_press pulses
//   key_level     debounced level, 1 = pressed
//   key_press     one-cycle pulse per accepted press (and per auto-repeat)
//   key_release   one-cycle pulse per accepted release
//
// state      | meaning
// IDLE       | key released and stable
// PRESS_PEND | press seen, counting stable pressed samples
// HELD       | press accepted, level high (repeat counting in repeat builds)
// REL_PEND   | release seen, counting stable released samples

module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                clk,
  input  logic                system_reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                mask,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CNT_MAX0 = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX  = (CNT_MAX0 > REPEAT_PERIOD) ? CNT_MAX0 : REPEAT_PERIOD;
  localparam int CW       = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_t;

  localparam logic [CW:0] DEB_T = (CW+1)'(DEBOUNCE_CYCLES);
`ifdef KEY_COND_REPEAT_EN
  localparam logic [CW:0] DLY_T = (CW+1)'(REPEAT_DELAY);
  localparam logic [CW:0] PER_T = (CW+1)'(REPEAT_PERIOD);
`endif

  // True when the count including this cycle's sample reaches the target.
  function automatic logic hit(input cnt_t c, input logic [CW:0] t);
    return ({1'b0, c} + (CW+1)'(1)) == t;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == {CW{1'b1}}) ? c : c + cnt_t'(1);
  endfunction

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  cnt_t                cnt_q   [NUM_KEYS];
  cnt_t                cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
`ifdef KEY_COND_REPEAT_EN
  // Set once the first repeat has fired; later repeats use REPEAT_PERIOD.
  logic [NUM_KEYS-1:0] rep_q, rep_d;
`endif

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
`ifdef KEY_COND_REPEAT_EN
      rep_q <= '0;
`endif
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
`ifdef KEY_COND_REPEAT_EN
      rep_q <= rep_d;
`endif
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
`ifdef KEY_COND_REPEAT_EN
    rep_d     = rep_q;
`endif
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        IDLE: begin
          if (!sync2_q[k]) begin
            state_d[k] = PRESS_PEND;
            cnt_d[k]   = cnt_t'(1);
          end else begin
            cnt_d[k] = '0;
          end
        end
        PRESS_PEND: begin
          if (sync2_q[k]) begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end else if (hit(cnt_q[k], DEB_T)) begin
            state_d[k] = HELD;
            cnt_d[k]   = '0;
            level_d[k] = 1'b1;
            press_d[k] = ~mask;
          end else begin
            cnt_d[k] = sat_inc(cnt_q[k]);
          end
        end
        HELD: begin
          if (sync2_q[k]) begin
            state_d[k] = REL_PEND;
            cnt_d[k]   = cnt_t'(1);
`ifdef KEY_COND_REPEAT_EN
            rep_d[k]   = 1'b0;
          end else if (hit(cnt_q[k], rep_q[k] ? PER_T : DLY_T)) begin
            cnt_d[k]   = '0;
            rep_d[k]   = 1'b1;
            press_d[k] = ~mask;
          end else begin
            cnt_d[k] = sat_inc(cnt_q[k]);
`endif
          end
        end
        REL_PEND: begin
          if (!sync2_q[k]) begin
            state_d[k] = HELD;
            cnt_d[k]   = '0;
          end else if (hit(cnt_q[k], DEB_T)) begin
            state_d[k]   = IDLE;
            cnt_d[k]     = '0;
            level_d[k]   = 1'b0;
            release_d[k] = 1'b1;
          end else begin
            cnt_d[k] = sat_inc(cnt_q[k]);
          end
        end
        default: begin
          state_d[k] = IDLE;
          cnt_d[k]   = '0;
          level_d[k] = 1'b0;
        end
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          system_reset;
  logic [NK-1:0] key_n;
  logic          mask;
  logic [NK-1:0] key_level, key_press, key_release;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .system_reset(system_reset), .key_n(key_n), .mask(mask),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int key; bit rel;} ev_t;
  ev_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic push(input int c, input int k, input bit rel);
    ev_t e;
    e.cyc = c; e.key = k; e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_level(input logic [NK-1:0] exp, input string name);
    checks++;
    if (key_level !== exp) begin
      errors++;
      $display("FAIL %s: cyc=%0d key_level=%b expected %b", name, cyc, key_level, exp);
    end
  endtask

  // Monitor: every pulse the DUT shows is matched against the next expected event.
  task automatic mon_event(input int k, input bit rel);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: cyc=%0d key=%0d, no pulse expected", rel ? "release" : "press", cyc, k);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.key != k || e.rel != rel) begin
        errors++;
        $display("FAIL pulse: got cyc=%0d key=%0d rel=%0d, expected cyc=%0d key=%0d rel=%0d",
                 cyc, k, rel, e.cyc, e.key, e.rel);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!system_reset) begin
      for (int k = 0; k < NK; k++) begin
        if (key_press[k])   mon_event(k, 1'b0);
        if (key_release[k]) mon_event(k, 1'b1);
      end
    end
  end

  int c, a;

  initial begin
    key_n = '1;
    mask = 1'b0;
    system_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_level, key_press, key_release} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b expected all 0", {key_level, key_press, key_release});
    end
    system_reset = 1'b0;
    @(negedge clk);

    // Single press and release of key 2.
    c = cyc;
    key_n[2] = 1'b0; push(c + 6, 2, 1'b0);
    wait_to(c + 5);  chk_level(4'b0000, "k2_before_accept");
    wait_to(c + 6);  chk_level(4'b0100, "k2_accept");
    wait_to(c + 8);  key_n[2] = 1'b1; push(c + 14, 2, 1'b1);
    wait_to(c + 13); chk_level(4'b0100, "k2_before_release");
    wait_to(c + 14); chk_level(4'b0000, "k2_release");
    wait_to(c + 18);

    // Bounce on key 1: three low cycles, rejected.
    c = cyc;
    key_n[1] = 1'b0;
    wait_to(c + 3);  key_n[1] = 1'b1;
    wait_to(c + 6);  chk_level(4'b0000, "k1_bounce_a");
    wait_to(c + 10); chk_level(4'b0000, "k1_bounce_b");
    wait_to(c + 12);

    // Key 0 held 20 cycles.
    c = cyc;
    key_n[0] = 1'b0; push(c + 6, 0, 1'b0);
`ifdef KEY_COND_REPEAT_EN
    push(c + 16, 0, 1'b0); push(c + 20, 0, 1'b0);
`endif
    wait_to(c + 20); key_n[0] = 1'b1; push(c + 26, 0, 1'b1);
    wait_to(c + 25); chk_level(4'b0001, "k0_held");
    wait_to(c + 26); chk_level(4'b0000, "k0_released");
    wait_to(c + 30);

    // Masked press of key 3; mask falls while held.
    c = cyc;
    mask = 1'b1; key_n[3] = 1'b0;
    wait_to(c + 6);  chk_level(4'b1000, "k3_masked_level");
    wait_to(c + 10); mask = 1'b0;
`ifdef KEY_COND_REPEAT_EN
    push(c + 16, 3, 1'b0); push(c + 20, 3, 1'b0);
`endif
    wait_to(c + 20); key_n[3] = 1'b1; push(c + 26, 3, 1'b1);
    wait_to(c + 26); chk_level(4'b0000, "k3_released");
    wait_to(c + 30);

    // Reset while key 2 is held, then re-debounce as a new press.
    c = cyc;
    key_n[2] = 1'b0; push(c + 6, 2, 1'b0);
    wait_to(c + 12);
    system_reset = 1'b1;
    #1;
    checks++;
    if ({key_level, key_press, key_release} !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%b expected all 0", {key_level, key_press, key_release});
    end
    wait_to(c + 14);
    system_reset = 1'b0;
    c = cyc;
    push(c + 6, 2, 1'b0);
    wait_to(c + 5);  chk_level(4'b0000, "k2_post_reset_pend");
    wait_to(c + 6);  chk_level(4'b0100, "k2_post_reset_accept");
    wait_to(c + 8);  key_n[2] = 1'b1; push(c + 14, 2, 1'b1);
    wait_to(c + 18);

    // Key 0 held about 30 cycles past acceptance (auto-repeat window).
    c = cyc;
    a = c + 6;
    key_n[0] = 1'b0; push(a, 0, 1'b0);
`ifdef KEY_COND_REPEAT_EN
    for (int i = 10; i <= 30; i += 4) push(a + i, 0, 1'b0);
`endif
    wait_to(a + 30); key_n[0] = 1'b1; push(a + 36, 0, 1'b1);
    wait_to(a + 35); chk_level(4'b0001, "k0_long_held");
    wait_to(a + 40);

    // Keys 0 and 1 together: simultaneous pulses.
    c = cyc;
    key_n[1:0] = 2'b00; push(c + 6, 0, 1'b0); push(c + 6, 1, 1'b0);
    wait_to(c + 6);  chk_level(4'b0011, "k01_accept");
    wait_to(c + 8);  key_n[1:0] = 2'b11; push(c + 14, 0, 1'b1); push(c + 14, 1, 1'b1);
    wait_to(c + 14); chk_level(4'b0000, "k01_release");
    wait_to(c + 20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, first at cyc=%0d key=%0d",
               exp_q.size(), exp_q[0].cyc, exp_q[0].key);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
